// File: rtl/seq_multiplier_sm.sv
// Sequential shift-add multiplier, signed/unsigned,
// with start/ready handshake and a one-cycle done pulse.
module seq_multiplier_sm #(
  parameter int L_word = 8
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [L_word-1:0]     word1,
  input  logic [L_word-1:0]     word2,
  output logic [2*L_word-1:0]   product,
  output logic                  ready,
  output logic                  done
);

  localparam int PW = 2 * L_word;

  typedef enum logic [1:0] {
    S_idle,
    S_run,
    S_fix,
    S_done
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [L_word-1:0] mplr_q, mplr_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;

  logic [L_word-1:0] mag1, mag2, mplr_sh;
  logic              launch;

  // Operand magnitudes; -2^(L-1) maps to 2^(L-1), still fits unsigned
  always_comb begin
    mag1 = word1;
    mag2 = word2;
    if (signed_mode && word1[L_word-1]) mag1 = -word1;
    if (signed_mode && word2[L_word-1]) mag2 = -word2;
  end

  assign ready   = (state_q == S_idle) || (state_q == S_done);
  assign launch  = ready && start;
  assign mplr_sh = mplr_q >> 1;
  assign product = prod_q;
  assign done    = done_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_idle, S_done: begin
        if (launch) begin
          neg_d  = signed_mode
                 & (word1[L_word-1] ^ word2[L_word-1]);
          prod_d = '0;
          if (mag1 == '0 || mag2 == '0) begin
            state_d = S_done;
            done_d  = 1'b1;
          end else begin
            mcand_d = {{L_word{1'b0}}, mag1};
            mplr_d  = mag2;
            state_d = S_run;
          end
        end
      end
      S_run: begin
        if (mplr_q[0]) prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_sh;
        if (mplr_sh == '0) state_d = S_fix;
      end
      S_fix: begin
        if (neg_q) prod_d = -prod_q;
        state_d = S_done;
        done_d  = 1'b1;
      end
      default: state_d = S_idle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_idle;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier_sm.sv
// Bench for seq_multiplier_sm: 8-bit directed/random
// jobs plus an exhaustive 4-bit sweep vs arithmetic model.
module tb_seq_multiplier_sm;

  logic        clock = 1'b0;
  logic        reset_b;

  logic        st8, sm8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        rdy8, dn8;

  logic        st4, sm4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        rdy4, dn4;

  int nchk = 0;
  int nbad = 0;

  always #5 clock = ~clock;

  seq_multiplier_sm #(.L_word(8)) u8 (
    .clock(clock), .reset_b(reset_b), .start(st8),
    .signed_mode(sm8), .word1(a8), .word2(b8),
    .product(p8), .ready(rdy8), .done(dn8)
  );

  seq_multiplier_sm #(.L_word(4)) u4 (
    .clock(clock), .reset_b(reset_b), .start(st4),
    .signed_mode(sm4), .word1(a4), .word2(b4),
    .product(p4), .ready(rdy4), .done(dn4)
  );

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic longint ref_prod(input int L,
                                      input bit sm,
                                      input longint a,
                                      input longint b);
    longint x, y, half;
    x = a;
    y = b;
    half = longint'(1) << (L - 1);
    if (sm) begin
      if (x >= half) x = x - (longint'(1) << L);
      if (y >= half) y = y - (longint'(1) << L);
    end
    return (x * y) & ((longint'(1) << (2 * L)) - 1);
  endfunction

  function automatic int ref_lat(input int L,
                                 input bit sm,
                                 input longint a,
                                 input longint b);
    longint ma, mb, half;
    int n;
    half = longint'(1) << (L - 1);
    ma = a;
    mb = b;
    if (sm && a >= half) ma = (longint'(1) << L) - a;
    if (sm && b >= half) mb = (longint'(1) << L) - b;
    if (ma == 0 || mb == 0) return 1;
    n = 0;
    while (mb > 0) begin
      n++;
      mb = mb >> 1;
    end
    return n + 2;
  endfunction

  task automatic drive(input bit w4, input bit s,
                       input bit sm,
                       input longint a, input longint b);
    if (w4) begin
      st4 = s; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      st8 = s; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // Called at #1 after the launch edge; follows the job to done.
  // pulse>0 re-asserts start with junk operands while busy.
  task automatic collect(input bit w4, input bit sm,
                         input longint a, input longint b,
                         input int pulse, input string tag);
    int     lat, rl, L, elat;
    logic   dn, rd;
    longint p;
    L   = w4 ? 4 : 8;
    lat = 1;
    rl  = 0;
    dn  = w4 ? dn4 : dn8;
    while (!dn && lat < 40) begin
      rd = w4 ? rdy4 : rdy8;
      if (!rd) rl++;
      if (lat <= pulse)
        drive(w4, 1, ~sm, $urandom, $urandom);
      else
        drive(w4, 0, ~sm, $urandom, $urandom);
      @(posedge clock);
      #1;
      lat++;
      dn = w4 ? dn4 : dn8;
    end
    drive(w4, 0, sm, a, b);
    p    = w4 ? longint'(p4) : longint'(p8);
    elat = ref_lat(L, sm, a, b);
    chk({tag, ":done"}, longint'(dn), 1);
    chk({tag, ":lat"}, lat, elat);
    chk({tag, ":rdylow"}, rl, (elat == 1) ? 0 : elat - 1);
    chk({tag, ":prod"}, p, ref_prod(L, sm, a, b));
  endtask

  // Launch on the next edge (caller is inside a ready cycle)
  task automatic relaunch(input bit w4, input bit sm,
                          input longint a, input longint b,
                          input string tag);
    drive(w4, 1, sm, a, b);
    @(posedge clock);
    #1;
    drive(w4, 0, ~sm, $urandom, $urandom);
    collect(w4, sm, a, b, 0, tag);
  endtask

  task automatic job(input bit w4, input bit sm,
                     input longint a, input longint b,
                     input string tag);
    @(negedge clock);
    relaunch(w4, sm, a, b, tag);
  endtask

  initial begin
    int     seen;
    longint ra, rb;
    bit     rs;
    reset_b = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst:prod", p8, 0);
    chk("rst:ready", rdy8, 1);
    chk("rst:done", dn8, 0);
    @(negedge clock);
    reset_b = 1'b1;

    job(0, 0, 255, 255, "u255x255");
    chk("u255x255:val", p8, 16'hFE01);
    @(posedge clock);
    #1;
    chk("donepulse", dn8, 0);
    chk("hold:prod", p8, 16'hFE01);
    chk("hold:ready", rdy8, 1);

    job(0, 1, 8'h80, 8'h80, "s-128x-128");
    chk("s-128x-128:val", p8, 16'h4000);
    job(0, 1, 8'hFD, 5, "s-3x5");
    chk("s-3x5:val", p8, 16'hFFF1);
    job(0, 1, 127, 8'hFF, "s127x-1");
    chk("s127x-1:val", p8, 16'hFF81);
    job(0, 0, 0, 77, "u0x77");
    job(0, 1, 8'h90, 0, "s-112x0");
    job(0, 1, 25, 8'hE7, "s25x-25");

    // start pulsed while busy must be ignored
    @(negedge clock);
    drive(0, 1, 0, 200, 100);
    @(posedge clock);
    #1;
    collect(0, 0, 200, 100, 3, "busystart");

    // start in the done cycle launches immediately
    relaunch(0, 1, 8'hF9, 9, "b2b1");
    relaunch(0, 0, 0, 3, "b2b2");
    relaunch(0, 0, 13, 11, "b2b3");

    // reset mid-run
    @(negedge clock);
    drive(0, 1, 0, 255, 255);
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_b = 1'b0;
    #1;
    chk("midrst:prod", p8, 0);
    chk("midrst:ready", rdy8, 1);
    chk("midrst:done", dn8, 0);
    @(negedge clock);
    reset_b = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (dn8) seen++;
    end
    chk("midrst:nodone", seen, 0);
    job(0, 0, 6, 7, "u6x7");
    chk("u6x7:val", p8, 42);

    // random 8-bit jobs, some back-to-back
    repeat (300) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) ra = 0;
      if ($urandom_range(0, 9) == 0) rb = 0;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        relaunch(0, rs, ra, rb, "rnd_b2b");
      else
        job(0, rs, ra, rb, "rnd");
    end

    // exhaustive 4-bit sweep, both modes
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          job(1, m[0], i, j, "ex4");

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nbad);
    $finish;
  end

endmodule
